// File: rtl/i2c_range_target.sv
// i2c_range_target
//   I2C target emulating the ultrasound range sensor. Responds at address ADDR
//   and exposes four byte registers: 0 command (R/W), 1 revision (RO),
//   2 range high, 3 range low (RO, snapshot taken at each START).
//
// Ports
//   CLOCK_50    system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   scl_in      SCL pad input (asynchronous)
//   sda_in      SDA pad input (asynchronous)
//   sda_oe      1 = pull SDA low, 0 = release (open drain)
//   meas_in     live range value from the fabric
//   cmd_out     last byte written to register 0
//   cmd_strobe  one-cycle pulse when cmd_out is updated
//   busy        high from address ACK until STOP, read NACK or address mismatch
module i2c_range_target #(
  parameter logic [6:0] ADDR = 7'h70,
  parameter logic [7:0] REV  = 8'h06
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] meas_in,
  output logic [7:0]  cmd_out,
  output logic        cmd_strobe,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR_BYTE,
    S_WR_ACK,
    S_RD_BYTE,
    S_RD_ACK,
    S_RD_LOAD
  } state_t;

  // [0],[1] synchroniser, [2] history stage
  logic [2:0]  scl_sync_q, scl_sync_d;
  logic [2:0]  sda_sync_q, sda_sync_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        first_wr_q, first_wr_d;
  logic        rw_q, rw_d;
  logic        sda_oe_q, sda_oe_d;
  logic        busy_q, busy_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        strobe_q, strobe_d;
  logic [15:0] rng_snap_q, rng_snap_d;

  logic        scl_cur, scl_prev, sda_cur, sda_prev;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_data;

  assign scl_cur   = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda_cur   = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];

  assign scl_rise  = scl_cur & ~scl_prev;
  assign scl_fall  = ~scl_cur & scl_prev;
  assign start_det = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev & ~sda_prev & sda_cur;

  assign rx_byte   = {rx_q[6:0], sda_cur};

  always_comb begin
    rd_data = cmd_q;
    case (ptr_q)
      2'd0: rd_data = cmd_q;
      2'd1: rd_data = REV;
      2'd2: rd_data = rng_snap_q[15:8];
      2'd3: rd_data = rng_snap_q[7:0];
      default: rd_data = cmd_q;
    endcase
  end

  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_in};
    sda_sync_d = {sda_sync_q[1:0], sda_in};
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    first_wr_d = first_wr_q;
    rw_d       = rw_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    cmd_d      = cmd_q;
    strobe_d   = 1'b0;
    rng_snap_d = rng_snap_q;

    if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      rng_snap_d = meas_in;
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      state_d    = S_ADDR;
    end else begin
      case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (rx_byte[7:1] == ADDR) begin
                busy_d  = 1'b1;
                rw_d    = rx_byte[0];
                state_d = S_ADDR_ACK;
              end else begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
              end
            end
          end
        end

        // First falling edge asserts ACK, the second (after the ACK clock)
        // either releases for a write or puts the first read bit on the bus.
        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              tx_d      = rd_data;
              sda_oe_d  = ~rd_data[7];
              bit_cnt_d = '0;
              state_d   = S_RD_BYTE;
            end else begin
              sda_oe_d   = 1'b0;
              first_wr_d = 1'b1;
              bit_cnt_d  = '0;
              state_d    = S_WR_BYTE;
            end
          end
        end

        S_WR_BYTE: begin
          if (scl_rise) begin
            rx_d      = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = S_WR_ACK;
              if (first_wr_q) begin
                ptr_d      = rx_byte[1:0];
                first_wr_d = 1'b0;
              end else begin
                if (ptr_q == 2'd0) begin
                  cmd_d    = rx_byte;
                  strobe_d = 1'b1;
                end
                ptr_d = ptr_q + 2'd1;
              end
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_WR_BYTE;
            end
          end
        end

        // MSB already on the bus at entry; each falling edge presents the
        // next bit, the eighth one releases SDA for the master's ACK.
        S_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 2'd1;
              state_d  = S_RD_ACK;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_cur) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_RD_LOAD;
            end
          end
        end

        S_RD_LOAD: begin
          if (scl_fall) begin
            tx_d      = rd_data;
            sda_oe_d  = ~rd_data[7];
            bit_cnt_d = '0;
            state_d   = S_RD_BYTE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      first_wr_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      cmd_q      <= '0;
      strobe_q   <= 1'b0;
      rng_snap_q <= '0;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      first_wr_q <= first_wr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      cmd_q      <= cmd_d;
      strobe_q   <= strobe_d;
      rng_snap_q <= rng_snap_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign cmd_out    = cmd_q;
  assign cmd_strobe = strobe_q;

endmodule

// File: tb/tb_i2c_range_target.sv
// tb_i2c_range_target
//   Bit-banged I2C master driving i2c_range_target over an open-drain SDA model.
//   Expected ACK bits and read bytes go into a scoreboard queue as stimulus is
//   issued; expected command bytes go into a second queue consumed on cmd_strobe.
module tb_i2c_range_target;

  localparam int unsigned Q = 300;  // quarter SCL period in ns

  logic        CLOCK_50;
  logic        rst_n;
  logic        scl_m;
  logic        sda_m;
  logic        sda_line;
  logic        sda_oe;
  logic [15:0] meas_in;
  logic [7:0]  cmd_out;
  logic        cmd_strobe;
  logic        busy;

  int          tests_run;
  int          failed;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_cmd_q[$];
  int unsigned oe_cnt;
  int unsigned busy_cnt;
  int unsigned busy_lo_cnt;

  assign sda_line = sda_m & ~sda_oe;

  i2c_range_target #(
    .ADDR(7'h70),
    .REV (8'h06)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .rst_n     (rst_n),
    .scl_in    (scl_m),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .meas_in   (meas_in),
    .cmd_out   (cmd_out),
    .cmd_strobe(cmd_strobe),
    .busy      (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sticky activity counters and the command scoreboard consumer
  initial begin
    oe_cnt      = 0;
    busy_cnt    = 0;
    busy_lo_cnt = 0;
  end

  always @(negedge CLOCK_50) begin
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_cnt = busy_cnt + 1;
    else busy_lo_cnt = busy_lo_cnt + 1;
    if (rst_n && cmd_strobe) begin
      if (exp_cmd_q.size() == 0) check("strobe_unexpected", 1, 0);
      else check("cmd_at_strobe", {24'd0, cmd_out}, {24'd0, exp_cmd_q.pop_front()});
    end
  end

  initial begin
    #1500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic i2c_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(2*Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    b = sda_line; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  // exp_nack: 0 = target should ACK, 1 = target should not respond
  task automatic write_byte(input logic [7:0] data, input logic exp_nack, input string tag);
    logic a;
    exp_q.push_back({7'd0, exp_nack});
    for (int i = 7; i >= 0; i--) write_bit(data[i]);
    read_bit(a);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check(tag, {31'd0, a}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic read_byte(input logic nack, input string tag);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic settle();
    repeat (8) @(negedge CLOCK_50);
  endtask

  int unsigned snap_a, snap_b;

  initial begin
    tests_run = 0;
    failed    = 0;
    rst_n     = 1'b0;
    scl_m     = 1'b1;
    sda_m     = 1'b1;
    meas_in   = 16'h0000;
    #100;
    check("rst_sda_oe", {31'd0, sda_oe}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_cmd_out", {24'd0, cmd_out}, 0);
    check("rst_strobe", {31'd0, cmd_strobe}, 0);
    rst_n = 1'b1;
    settle();

    // Command write
    i2c_start();
    write_byte(8'hE0, 1'b0, "cw_addr_ack");
    check("cw_busy_after_ack", {31'd0, busy}, 1);
    snap_a = busy_lo_cnt;
    write_byte(8'h00, 1'b0, "cw_ptr_ack");
    exp_cmd_q.push_back(8'h51);
    write_byte(8'h51, 1'b0, "cw_data_ack");
    check("cw_busy_held", busy_lo_cnt - snap_a, 0);
    i2c_stop();
    settle();
    check("cw_cmd_out", {24'd0, cmd_out}, 32'h51);
    check("cw_busy_after_stop", {31'd0, busy}, 0);
    check("cw_sda_oe_after_stop", {31'd0, sda_oe}, 0);
    check("cw_strobe_consumed", exp_cmd_q.size(), 0);

    // Range read with repeated START and mid-read measurement change
    meas_in = 16'h1234;
    i2c_start();
    write_byte(8'hE0, 1'b0, "rr_waddr_ack");
    write_byte(8'h02, 1'b0, "rr_ptr_ack");
    i2c_start();
    write_byte(8'hE1, 1'b0, "rr_raddr_ack");
    meas_in = 16'hFFFF;
    exp_q.push_back(8'h12);
    read_byte(1'b0, "rr_hi");
    exp_q.push_back(8'h34);
    read_byte(1'b1, "rr_lo");
    check("rr_busy_after_nack", {31'd0, busy}, 0);
    i2c_stop();
    settle();

    // Address mismatch
    meas_in = 16'h1234;
    snap_a = oe_cnt;
    snap_b = busy_cnt;
    i2c_start();
    write_byte(8'hE2, 1'b1, "mm_addr_nack");
    write_byte(8'h00, 1'b1, "mm_data_nack");
    i2c_stop();
    settle();
    check("mm_no_oe", oe_cnt - snap_a, 0);
    check("mm_no_busy", busy_cnt - snap_b, 0);
    check("mm_cmd_out", {24'd0, cmd_out}, 32'h51);

    // Pointer wrap: 3 -> 0 -> 1, then a pointer-less read lands on 2
    i2c_start();
    write_byte(8'hE0, 1'b0, "pw_waddr_ack");
    write_byte(8'h03, 1'b0, "pw_ptr_ack");
    i2c_stop();
    i2c_start();
    write_byte(8'hE1, 1'b0, "pw_raddr_ack");
    exp_q.push_back(8'h34);
    read_byte(1'b0, "pw_reg3");
    exp_q.push_back(8'h51);
    read_byte(1'b0, "pw_reg0");
    exp_q.push_back(8'h06);
    read_byte(1'b1, "pw_reg1");
    i2c_stop();
    i2c_start();
    write_byte(8'hE1, 1'b0, "pw_cont_addr_ack");
    exp_q.push_back(8'h12);
    read_byte(1'b1, "pw_cont_reg2");
    i2c_stop();
    settle();

    // Abort: STOP after four bits of a register-0 data byte
    i2c_start();
    write_byte(8'hE0, 1'b0, "ab_addr_ack");
    write_byte(8'h00, 1'b0, "ab_ptr_ack");
    write_bit(1'b1);
    write_bit(1'b0);
    write_bit(1'b1);
    write_bit(1'b0);
    i2c_stop();
    settle();
    check("ab_cmd_out", {24'd0, cmd_out}, 32'h51);
    check("ab_busy", {31'd0, busy}, 0);

    // Reset mid-read: reg0 = 0x51, MSB 0, so SDA is pulled right after the address ACK
    i2c_start();
    write_byte(8'hE1, 1'b0, "rm_addr_ack");
    check("rm_oe_before_reset", {31'd0, sda_oe}, 1);
    rst_n = 1'b0;
    #1;
    check("rm_oe_in_reset", {31'd0, sda_oe}, 0);
    check("rm_cmd_in_reset", {24'd0, cmd_out}, 0);
    check("rm_busy_in_reset", {31'd0, busy}, 0);
    #99;
    rst_n = 1'b1;
    settle();
    i2c_stop();
    settle();

    // Recovery: pointer back at 0, then a full write and read-back
    i2c_start();
    write_byte(8'hE1, 1'b0, "rc_raddr_ack");
    exp_q.push_back(8'h00);
    read_byte(1'b1, "rc_reg0_after_reset");
    i2c_stop();
    i2c_start();
    write_byte(8'hE0, 1'b0, "rc_waddr_ack");
    write_byte(8'h00, 1'b0, "rc_ptr_ack");
    exp_cmd_q.push_back(8'hC3);
    write_byte(8'hC3, 1'b0, "rc_data_ack");
    i2c_start();
    write_byte(8'hE0, 1'b0, "rc_waddr2_ack");
    write_byte(8'h00, 1'b0, "rc_ptr2_ack");
    i2c_start();
    write_byte(8'hE1, 1'b0, "rc_raddr2_ack");
    exp_q.push_back(8'hC3);
    read_byte(1'b1, "rc_readback");
    i2c_stop();
    settle();
    check("rc_cmd_out", {24'd0, cmd_out}, 32'hC3);
    check("sb_cmd_left", exp_cmd_q.size(), 0);
    check("sb_data_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
